// File: rtl/riscv_test_monitor_if.sv
// Register-file write-back port as seen by the test monitor.
// wb_en qualifies wb_addr/wb_data for one cycle; there is no backpressure, so no ready.
interface riscv_test_monitor_if;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  modport master (output wb_en, wb_addr, wb_data);
  modport slave  (input  wb_en, wb_addr, wb_data);
endinterface

// File: rtl/riscv_test_monitor.sv
// Pass/fail monitor for riscv-tests: shadows x3/x26/x27 from write-back and
// reports done/pass/fail/timeout with the failing test number and run length.
module riscv_test_monitor #(
  parameter int unsigned SETTLE_CYCLES  = 20,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd200000,
  parameter int          CNT_W          = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  riscv_test_monitor_if.slave    wb,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic                   timeout,
  output logic [31:0]            fail_testnum,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [2:0]             dbg_state
);

  localparam logic [2:0] ST_RUN     = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_PASS    = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] x3_q, x26_q, x27_q;
  logic [31:0] x3_nxt, x26_nxt, x27_nxt;
  logic [16:0] settle_q;
  logic [31:0] tcnt_q;
  logic        x26_hit, timeout_hit, settle_last, terminal_d;

  // Post-update shadow values: same-cycle writes count for detection and sampling.
  always_comb begin
    x3_nxt  = x3_q;
    x26_nxt = x26_q;
    x27_nxt = x27_q;
    if (wb.wb_en) begin
      case (wb.wb_addr)
        5'd3:    x3_nxt  = wb.wb_data;
        5'd26:   x26_nxt = wb.wb_data;
        5'd27:   x27_nxt = wb.wb_data;
        default: ;
      endcase
    end
  end

  assign x26_hit     = (x26_nxt == 32'd1);
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (tcnt_q == TIMEOUT_CYCLES - 32'd1);
  assign settle_last = (settle_q == 17'(SETTLE_CYCLES));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (x26_hit)          state_d = ST_SETTLE;
        else if (timeout_hit) state_d = ST_TIMEOUT;
      end
      ST_SETTLE: begin
        if (settle_last) state_d = (x27_nxt == 32'd1) ? ST_PASS : ST_FAIL;
      end
      default: ;
    endcase
  end

  assign terminal_d = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      state_q      <= ST_RUN;
      x3_q         <= '0;
      x26_q        <= '0;
      x27_q        <= '0;
      settle_q     <= '0;
      tcnt_q       <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_testnum <= '0;
      cycle_count  <= '0;
    end else begin
      state_q <= state_d;
      if (!done) begin
        x3_q  <= x3_nxt;
        x26_q <= x26_nxt;
        x27_q <= x27_nxt;
        if (cycle_count != {CNT_W{1'b1}}) cycle_count <= cycle_count + CNT_W'(1);
      end
      if (state_q == ST_RUN) begin
        settle_q <= '0;
        if (tcnt_q != 32'hFFFF_FFFF) tcnt_q <= tcnt_q + 32'd1;
      end else if (state_q == ST_SETTLE) begin
        settle_q <= settle_q + 17'd1;
      end
      // Outputs latch once, on the edge the FSM enters a terminal state.
      if (!done && terminal_d) begin
        done         <= 1'b1;
        pass         <= (state_d == ST_PASS);
        fail         <= (state_d == ST_FAIL);
        timeout      <= (state_d == ST_TIMEOUT);
        fail_testnum <= x3_nxt;
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: table of settle-window scenarios plus
// hand sequences for timeout, timeout/x26 race, ignored writes, reset and saturation.
module tb_riscv_test_monitor;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  riscv_test_monitor_if wbif();

  logic        done, pass, fail, timeout;
  logic [31:0] fail_testnum, cycle_count;
  logic [2:0]  dbg_state;

  logic        s_done, s_pass, s_fail, s_timeout;
  logic [31:0] s_fail_testnum;
  logic [3:0]  s_cycle_count;
  logic [2:0]  s_dbg_state;

  riscv_test_monitor #(.SETTLE_CYCLES(20), .TIMEOUT_CYCLES(32'd100), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .clear(clear), .wb(wbif.slave),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .fail_testnum(fail_testnum), .cycle_count(cycle_count), .dbg_state(dbg_state)
  );

  // Narrow counter, timeout disabled: exercises saturation and the 0 setting.
  riscv_test_monitor #(.SETTLE_CYCLES(20), .TIMEOUT_CYCLES(32'd0), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .wb(wbif.slave),
    .done(s_done), .pass(s_pass), .fail(s_fail), .timeout(s_timeout),
    .fail_testnum(s_fail_testnum), .cycle_count(s_cycle_count), .dbg_state(s_dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] x3;
    int          x3_off;
    logic [31:0] x27;
    int          x27_off;
    logic        exp_pass;
    logic        exp_fail;
    logic [31:0] exp_tn;
  } scen_t;

  scen_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic [4:0] a, input logic [31:0] d);
    wbif.wb_en   = en;
    wbif.wb_addr = a;
    wbif.wb_data = d;
    @(posedge clk);
    #1;
    wbif.wb_en   = 1'b0;
    wbif.wb_addr = 5'd0;
    wbif.wb_data = 32'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1'b0, 5'd0, 32'd0);
    clear = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_pass"}, pass, 0);
    chk({nm, "_fail"}, fail, 0);
    chk({nm, "_timeout"}, timeout, 0);
    chk({nm, "_testnum"}, fail_testnum, 0);
    chk({nm, "_cycles"}, cycle_count, 0);
    chk({nm, "_state"}, dbg_state, 0);
  endtask

  initial begin
    int pre;
    wbif.wb_en   = 1'b0;
    wbif.wb_addr = 5'd0;
    wbif.wb_data = 32'd0;

    //            x3      x3_off  x27     x27_off pass fail tn
    tbl[0] = '{32'd5, -1, 32'd1, 1,  1'b1, 1'b0, 32'd5};
    tbl[1] = '{32'd7, -1, 32'd0, -1, 1'b0, 1'b1, 32'd7};
    tbl[2] = '{32'd9, 11, 32'd1, 10, 1'b1, 1'b0, 32'd9};
    tbl[3] = '{32'd4, -1, 32'd1, 21, 1'b1, 1'b0, 32'd4};
    tbl[4] = '{32'd6, 21, 32'd1, -1, 1'b1, 1'b0, 32'd6};
    tbl[5] = '{32'd8, -1, 32'd1, 22, 1'b0, 1'b1, 32'd8};
    tbl[6] = '{32'd3, 23, 32'd2, -1, 1'b0, 1'b1, 32'd0};

    idle(2);
    reset = 1'b1;
    chk_zero("reset");
    chk("reset_sat_cycles", s_cycle_count, 0);

    for (int s = 0; s < 7; s++) begin
      do_clear();
      chk_zero($sformatf("s%0d_clear", s));
      pre = 0;
      if (tbl[s].x3_off < 0)  begin step(1'b1, 5'd3,  tbl[s].x3);  pre++; end
      if (tbl[s].x27_off < 0) begin step(1'b1, 5'd27, tbl[s].x27); pre++; end
      step(1'b1, 5'd26, 32'd1);
      chk($sformatf("s%0d_settle_state", s), dbg_state, 1);
      for (int k = 1; k <= 24; k++) begin
        if (tbl[s].x3_off == k)       step(1'b1, 5'd3,  tbl[s].x3);
        else if (tbl[s].x27_off == k) step(1'b1, 5'd27, tbl[s].x27);
        else                          step(1'b0, 5'd0,  32'd0);
        if (k == 20) chk($sformatf("s%0d_done_early", s), done, 0);
        if (k == 21 || k == 24) begin
          chk($sformatf("s%0d_k%0d_done", s, k), done, 1);
          chk($sformatf("s%0d_k%0d_pass", s, k), pass, tbl[s].exp_pass);
          chk($sformatf("s%0d_k%0d_fail", s, k), fail, tbl[s].exp_fail);
          chk($sformatf("s%0d_k%0d_timeout", s, k), timeout, 0);
          chk($sformatf("s%0d_k%0d_testnum", s, k), fail_testnum, tbl[s].exp_tn);
          chk($sformatf("s%0d_k%0d_cycles", s, k), cycle_count, pre + 22);
          chk($sformatf("s%0d_k%0d_state", s, k), dbg_state, tbl[s].exp_pass ? 2 : 3);
        end
      end
    end

    // Timeout at exactly TIMEOUT_CYCLES; the disabled monitor never times out and saturates.
    do_clear();
    idle(99);
    chk("to_early_done", done, 0);
    chk("sat_cycles", s_cycle_count, 4'hF);
    chk("sat_done", s_done, 0);
    idle(1);
    chk("to_done", done, 1);
    chk("to_timeout", timeout, 1);
    chk("to_pass", pass, 0);
    chk("to_fail", fail, 0);
    chk("to_cycles", cycle_count, 100);
    chk("to_state", dbg_state, 4);
    idle(5);
    chk("to_cycles_frozen", cycle_count, 100);
    chk("sat_no_timeout", s_timeout, 0);
    chk("sat_state_run", s_dbg_state, 0);

    // x26 arrives on the same edge the timeout would fire: settle wins.
    do_clear();
    idle(99);
    step(1'b1, 5'd26, 32'd1);
    chk("race_state", dbg_state, 1);
    chk("race_timeout", timeout, 0);
    idle(20);
    chk("race_done_early", done, 0);
    idle(1);
    chk("race_done", done, 1);
    chk("race_fail", fail, 1);
    chk("race_timeout_final", timeout, 0);
    chk("race_cycles", cycle_count, 121);

    // Writes to x0, x25, and a non-1 value to x26 do not trigger.
    do_clear();
    step(1'b1, 5'd0, 32'd1);
    step(1'b1, 5'd25, 32'd1);
    step(1'b1, 5'd26, 32'd2);
    idle(3);
    chk("ign_done", done, 0);
    chk("ign_state", dbg_state, 0);

    // Reset mid-settle aborts and clears the shadows.
    step(1'b1, 5'd26, 32'd1);
    idle(10);
    chk("mid_state", dbg_state, 1);
    reset = 1'b0;
    step(1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    chk_zero("mid_reset");
    idle(3);
    chk("mid_after_state", dbg_state, 0);

    // Full pass afterwards; x26 dropped back to 0 inside settle does not abort.
    step(1'b1, 5'd3, 32'd11);
    step(1'b1, 5'd27, 32'd1);
    step(1'b1, 5'd26, 32'd1);
    idle(4);
    step(1'b1, 5'd26, 32'd0);
    idle(15);
    chk("rerun_done_early", done, 0);
    idle(1);
    chk("rerun_done", done, 1);
    chk("rerun_pass", pass, 1);
    chk("rerun_fail", fail, 0);
    chk("rerun_testnum", fail_testnum, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
